// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: ALU compare, condition resolve, fetch redirect.
// Also handles ALU timeout, misaligned-target error and flush abort.
module branch_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  output logic            alu_req,
  input  logic            alu_gnt,
  input  logic            alu_done,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  input  logic            flush,
  output logic            br_done,
  output logic            br_taken,
  output logic            br_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESOLVE,
    S_REDIRECT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      type_q, type_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            zero_q, zero_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            rdv_q, rdv_d;
  logic [XLEN-1:0] rdpc_q, rdpc_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            taken_q, taken_d;
  logic            err_q, err_d;

  logic            cond;
  logic            nop_type;
  logic [XLEN-1:0] target;

  assign nop_type = (branch_type == 3'd0) || (branch_type == 3'd7);
  assign target   = pc_q + imm_q;

  always_comb begin
    cond = 1'b0;
    unique case (type_q)
      3'd1:    cond = zero_q;
      3'd2:    cond = !zero_q;
      3'd3:    cond = lt_q;
      3'd4:    cond = !lt_q;
      3'd5:    cond = ltu_q;
      3'd6:    cond = !ltu_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdv_d   = rdv_q;
    rdpc_d  = rdpc_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    taken_d = 1'b0;
    err_d   = 1'b0;
    // flush overrides every state, including a same-cycle br_valid
    if (flush) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      rdv_d   = 1'b0;
      ready_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (br_valid) begin
            type_d = branch_type;
            pc_d   = br_pc;
            imm_d  = br_imm;
            if (nop_type) begin
              done_d = 1'b1;
            end else begin
              state_d = S_REQ;
              req_d   = 1'b1;
              ready_d = 1'b0;
            end
          end
        end
        S_REQ: begin
          if (alu_gnt) begin
            state_d = S_WAIT;
            req_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            zero_d  = alu_zero;
            lt_d    = alu_lt;
            ltu_d   = alu_ltu;
            state_d = S_RESOLVE;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RESOLVE: begin
          if (!cond) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else if (target[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            rdv_d   = 1'b1;
            rdpc_d  = target;
            state_d = S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            rdv_d   = 1'b0;
            done_d  = 1'b1;
            taken_d = 1'b1;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          rdv_d   = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rdpc_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdv_q   <= rdv_d;
      rdpc_q  <= rdpc_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign br_ready       = ready_q;
  assign alu_req        = req_q;
  assign redirect_valid = rdv_q;
  assign redirect_pc    = rdpc_q;
  assign br_done        = done_q;
  assign br_taken       = taken_q;
  assign br_err         = err_q;

endmodule
